sparse_frame_expander: RTL and testbench

//  Receive-side counterpart of the sparsifying threshold stage.

---
 rtl/cs_pkg.sv | 22 ++
 rtl/cs_sat_add.sv | 22 ++
 rtl/sparse_frame_expander.sv | 172 +++++++++++++++++
 tb/tb_sparse_frame_expander.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cs_pkg.sv
// Shared constants and state encoding for the sparse coefficient link stages.
package cs_pkg;

  localparam int unsigned N    = 2048;  // samples per frame
  localparam int unsigned IDW  = 12;    // index width
  localparam int unsigned DW   = 12;    // signed sample width

  // DC offset restored to every sample; shared with the threshold stage
  localparam logic signed [DW-1:0] MEAN = 12'sd958;

  localparam logic [IDW-1:0] FRAME_LEN  = IDW'(N);
  localparam logic [IDW-1:0] LAST_IDX   = IDW'(N - 1);
  // All-ones index marks an empty frame; it can never match a sample index
  localparam logic [IDW-1:0] IDX_MARKER = '1;

  typedef enum logic [1:0] {
    StIdle,
    StExpand,
    StDrain
  } state_e;

endpackage

// File: rtl/cs_sat_add.sv
// Signed saturating adder: y = clamp(a + b) to the W-bit signed range.
module cs_sat_add #(
  parameter int unsigned W = 12
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] y
);

  logic signed [W:0] sum;

  // Add with one guard bit, clamp when the top two bits disagree
  always_comb begin
    sum = {a[W-1], a} + {b[W-1], b};
    if (sum[W] != sum[W-1]) begin
      y = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      y = sum[W-1:0];
    end
  end

endmodule

// File: rtl/sparse_frame_expander.sv
// Sparse (index, value) pairs -> dense N-sample frame with MEAN restored.
// Optional build macro SFE_ORDER_CHECK_EN enables the sticky protocol error flag.
module sparse_frame_expander
  import cs_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IDW-1:0]        in_idx,
  input  logic signed [DW-1:0]  in_val,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [DW-1:0]  out_sample,
  output logic [IDW-1:0]        out_id,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  state_e                state_q, state_d;
  logic [IDW-1:0]        cnt_q, cnt_d;
  logic                  pair_vld_q, pair_vld_d;
  logic [IDW-1:0]        pair_idx_q, pair_idx_d;
  logic signed [DW-1:0]  pair_val_q, pair_val_d;
  logic                  last_seen_q, last_seen_d;
  logic                  done_q, done_d;

  logic                  expanding, match, stale, out_hs, consume, at_end, accept, frame_close;
  logic signed [DW-1:0]  sat_sum;

  cs_sat_add #(
    .W (DW)
  ) u_sat_add (
    .a (pair_val_q),
    .b (MEAN),
    .y (sat_sum)
  );

  // Handshake qualifiers, all derived from registered state plus the two ready/valid inputs
  always_comb begin
    expanding   = (state_q == StExpand);
    match       = pair_vld_q && (pair_idx_q == cnt_q);
    stale       = pair_vld_q && (pair_idx_q < cnt_q);
    out_hs      = expanding && out_ready;
    consume     = out_hs && match;
    at_end      = (cnt_q == LAST_IDX);
    accept      = in_valid && in_ready;
    // Frame closes cleanly if in_last was seen earlier or arrives on the final handshake
    frame_close = last_seen_q || (accept && in_last);
  end

  // Outputs: dense side from registered state only; in_ready may follow out_ready
  always_comb begin
    out_valid  = expanding;
    out_id     = expanding ? cnt_q : '0;
    out_last   = expanding && at_end;
    out_sample = expanding ? (match ? sat_sum : MEAN) : '0;
    busy       = (state_q != StIdle);
    done       = done_q;
    unique case (state_q)
      StExpand: in_ready = !last_seen_q && (!pair_vld_q || consume || stale);
      StDrain:  in_ready = 1'b1;
      default:  in_ready = 1'b0;
    endcase
  end

  // Next-state: FSM, sample counter and the single-entry pair register
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pair_vld_d  = pair_vld_q;
    pair_idx_d  = pair_idx_q;
    pair_val_d  = pair_val_q;
    last_seen_d = last_seen_q;
    done_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StExpand;
          cnt_d       = '0;
          pair_vld_d  = 1'b0;
          last_seen_d = 1'b0;
        end
      end
      StExpand: begin
        if (accept) begin
          pair_vld_d = 1'b1;
          pair_idx_d = in_idx;
          pair_val_d = in_val;
          if (in_last) last_seen_d = 1'b1;
        end else if (consume || stale) begin
          pair_vld_d = 1'b0;
        end
        if (out_hs) begin
          cnt_d = cnt_q + 1'b1;
          if (at_end) begin
            cnt_d      = '0;
            pair_vld_d = 1'b0;  // anything still pending is dropped
            if (frame_close) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end else begin
              state_d = StDrain;
            end
          end
        end
      end
      StDrain: begin
        if (accept && in_last) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers, synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      pair_vld_q  <= 1'b0;
      pair_idx_q  <= '0;
      pair_val_q  <= '0;
      last_seen_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pair_vld_q  <= pair_vld_d;
      pair_idx_q  <= pair_idx_d;
      pair_val_q  <= pair_val_d;
      last_seen_q <= last_seen_d;
      done_q      <= done_d;
    end
  end

`ifdef SFE_ORDER_CHECK_EN
  logic err_q, err_d;
  logic bad_idx, end_drop;

  // Sticky error: stale drop, out-of-range index, pending pair lost at close, or DRAIN entry
  always_comb begin
    err_d    = err_q;
    bad_idx  = accept && (in_idx >= FRAME_LEN) && (in_idx != IDX_MARKER);
    end_drop = (pair_vld_q && !consume && !stale && (pair_idx_q != IDX_MARKER)) ||
               (accept && (in_idx != IDX_MARKER));
    if (state_q == StIdle) begin
      if (start) err_d = 1'b0;
    end else if (expanding) begin
      if (stale || bad_idx) err_d = 1'b1;
      if (out_hs && at_end && (end_drop || !frame_close)) err_d = 1'b1;
    end
  end

  // Error flag register
  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sparse_frame_expander.sv
// Directed self-checking bench for sparse_frame_expander.
module tb_sparse_frame_expander;

`ifdef SFE_ORDER_CHECK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset, start, in_valid, in_ready, in_last;
  logic [11:0]        in_idx;
  logic signed [11:0] in_val;
  logic               out_valid, out_ready, out_last, busy, done, err;
  logic signed [11:0] out_sample;
  logic [11:0]        out_id;

  int tests = 0;
  int fails = 0;

  logic signed [11:0] exp_s [2048];
  int                 p_idx [8];
  int                 p_val [8];
  bit                 p_last [8];

  always #5 clk = ~clk;

  sparse_frame_expander u_dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_idx     (in_idx),
    .in_val     (in_val),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sample (out_sample),
    .out_id     (out_id),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic fill_mean();
    for (int i = 0; i < 2048; i++) exp_s[i] = 12'sd958;
  endtask

  task automatic set_pair(input int i, input int idx, input int val, input bit last);
    p_idx[i]  = idx;
    p_val[i]  = val;
    p_last[i] = last;
  endtask

  // Pulse start, then feed pairs and collect samples until 2048 are taken or abort_at reached.
  // Leaves the bench on a falling edge one cycle after the last handshake.
  task automatic run_frame(input int npairs, input bit bp, input int abort_at,
                           output int emitted, output int mism);
    int pi = 0;
    int cyc = 0;
    bit stall = 1'b0;
    logic [11:0] h_id;
    logic signed [11:0] h_s;
    logic h_l;
    emitted = 0;
    mism    = 0;
    start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    while (emitted < 2048 && cyc < 20000) begin
      if (abort_at >= 0 && emitted == abort_at) break;
      out_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_valid  = (pi < npairs);
      if (pi < npairs) begin
        in_idx  = 12'(p_idx[pi]);
        in_val  = 12'(p_val[pi]);
        in_last = p_last[pi];
      end
      #1;
      if (stall && (out_id !== h_id || out_sample !== h_s || out_last !== h_l)) mism++;
      if (out_valid !== 1'b1) begin
        mism++;
      end else begin
        if (out_id !== 12'(emitted)) mism++;
        if (out_ready) begin
          if (out_sample !== exp_s[emitted] || out_last !== (emitted == 2047)) mism++;
          emitted++;
        end
      end
      stall = out_valid && !out_ready;
      h_id  = out_id;
      h_s   = out_sample;
      h_l   = out_last;
      if (in_valid && in_ready) pi++;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    check("frame_cycle_budget", (cyc < 20000), 1);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic close_checks(input string tag, input bit exp_err);
    #1;
    check({tag, "_done"}, done, 1);
    check({tag, "_idle"}, busy, 0);
    check({tag, "_err"}, err, exp_err);
    @(posedge clk);
    @(negedge clk);
    #1;
    check({tag, "_done_pulse"}, done, 0);
  endtask

  int em, mm;

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_idx = '0; in_val = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_outputs",
          {in_ready, out_valid, out_sample, out_id, out_last, busy, done, err}, 0);
    reset = 1'b0;
    @(negedge clk);

    // 1: basic frame, full rate
    fill_mean();
    exp_s[5] = 12'sd1058; exp_s[6] = 12'sd908; exp_s[2047] = 12'sd968;
    set_pair(0, 5, 100, 0); set_pair(1, 6, -50, 0); set_pair(2, 2047, 10, 1);
    run_frame(3, 1'b0, -1, em, mm);
    check("t1_count", em, 2048);
    check("t1_samples", mm, 0);
    close_checks("t1", 1'b0);

    // 2: same frame under random backpressure
    run_frame(3, 1'b1, -1, em, mm);
    check("t2_count", em, 2048);
    check("t2_samples_stable", mm, 0);
    close_checks("t2", 1'b0);

    // 3: saturation high and large negative value
    fill_mean();
    exp_s[10] = 12'sd2047; exp_s[11] = -12'sd1090;
    set_pair(0, 10, 2047, 0); set_pair(1, 11, -2048, 1);
    run_frame(2, 1'b0, -1, em, mm);
    check("t3_count", em, 2048);
    check("t3_samples", mm, 0);
    close_checks("t3", 1'b0);

    // 4: out-of-order pair is dropped
    fill_mean();
    exp_s[20] = 12'sd959; exp_s[30] = 12'sd959;
    set_pair(0, 20, 1, 0); set_pair(1, 15, 1, 0); set_pair(2, 30, 1, 1);
    run_frame(3, 1'b0, -1, em, mm);
    check("t4_count", em, 2048);
    check("t4_samples", mm, 0);
    close_checks("t4", ChkEn);

    // 5: no last pair -> DRAIN until in_last
    fill_mean();
    exp_s[100] = 12'sd963;
    set_pair(0, 100, 5, 0);
    run_frame(1, 1'b0, -1, em, mm);
    check("t5_count", em, 2048);
    check("t5_samples", mm, 0);
    #1;
    check("t5_drain_busy", busy, 1);
    check("t5_drain_noout", out_valid, 0);
    check("t5_drain_ready", in_ready, 1);
    check("t5_err", err, ChkEn);
    for (int i = 0; i < 3; i++) begin
      check("t5_no_done", done, 0);
      @(posedge clk);
      @(negedge clk);
      #1;
    end
    in_valid = 1'b1; in_idx = 12'd7; in_val = 12'sd3; in_last = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("t5_nonlast_no_done", done, 0);
    check("t5_still_drain", busy, 1);
    in_last = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    close_checks("t5", ChkEn);

    // 6: reset mid-frame, then empty frame
    fill_mean();
    exp_s[5] = 12'sd1058;
    set_pair(0, 5, 100, 0); set_pair(1, 2047, 10, 1);
    run_frame(2, 1'b0, 700, em, mm);
    check("t6_abort_point", em, 700);
    check("t6_samples_before_abort", mm, 0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("t6_reset_outputs",
          {in_ready, out_valid, out_sample, out_id, out_last, busy, done, err}, 0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("t6_no_done_after_reset", done, 0);
    fill_mean();
    set_pair(0, 4095, 0, 1);
    run_frame(1, 1'b0, -1, em, mm);
    check("t6_empty_count", em, 2048);
    check("t6_empty_samples", mm, 0);
    close_checks("t6_empty", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
